// File: rtl/cheri_pkg.sv
// Shared types for the CHERI multicycle sequencer: FSM state encoding and the
// default revocation-lookup timeout.
package cheri_pkg;

  typedef enum logic [2:0] {
    MC_IDLE,
    MC_SBND2,
    MC_LSU_WAIT,
    MC_TRVK_REQ,
    MC_TRVK_WAIT,
    MC_DONE
  } mc_state_e;

  localparam int unsigned TRVK_TIMEOUT_DEF = 16;

endpackage

// File: rtl/cheri_mc_seq.sv
// EX-stage sequencer for multicycle CHERI ops: two-cycle bounds ops and the
// load-barrier CLC (LSU data -> revocation lookup -> clear-tag decision).
module cheri_mc_seq
  import cheri_pkg::*;
#(
  parameter bit          CheriSBND2  = 1'b0,
  parameter int unsigned TrvkTimeout = TRVK_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic op_sbnd_i,
  input  logic op_clc_i,
  input  logic flush_i,
  input  logic lsu_resp_valid_i,
  input  logic lsu_resp_err_i,
  input  logic lsu_tag_i,
  output logic trvk_req_o,
  input  logic trvk_gnt_i,
  input  logic trvk_rsp_valid_i,
  input  logic trvk_rsp_revoked_i,
  output logic busy_o,
  output logic done_o,
  output logic sbnd_stage_o,
  output logic clr_tag_o,
  output logic err_o
);

  localparam int unsigned CntW = $clog2(TrvkTimeout);
  localparam logic [CntW-1:0] CntLast = CntW'(TrvkTimeout - 1);

  mc_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_pending_q, rsp_pending_d;
  logic            clr_tag_q, clr_tag_d;
  logic            err_q, err_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    // Any lookup response retires the single outstanding request, wherever it lands.
    rsp_pending_d = rsp_pending_q & ~trvk_rsp_valid_i;
    clr_tag_d     = 1'b0;
    err_d         = 1'b0;
    trvk_req_o    = 1'b0;

    unique case (state_q)
      MC_IDLE: begin
        if (start_i && !flush_i) begin
          if (op_clc_i) begin
            state_d = MC_LSU_WAIT;
          end else if (op_sbnd_i && CheriSBND2) begin
            state_d = MC_SBND2;
          end
        end
      end
      MC_SBND2: state_d = MC_IDLE;
      MC_LSU_WAIT: begin
        if (lsu_resp_valid_i) begin
          if (lsu_resp_err_i) begin
            state_d = MC_DONE;
            err_d   = 1'b1;
          end else if (!lsu_tag_i) begin
            state_d = MC_DONE;
          end else begin
            state_d = MC_TRVK_REQ;
          end
        end
      end
      MC_TRVK_REQ: begin
        trvk_req_o = ~rsp_pending_q;
        if (trvk_req_o && trvk_gnt_i) begin
          state_d       = MC_TRVK_WAIT;
          cnt_d         = '0;
          rsp_pending_d = 1'b1;
        end
      end
      MC_TRVK_WAIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (trvk_rsp_valid_i) begin
          state_d   = MC_DONE;
          clr_tag_d = trvk_rsp_revoked_i;
        end else if (cnt_q == CntLast) begin
          // No answer in time: treat the capability as revoked.
          state_d   = MC_DONE;
          clr_tag_d = 1'b1;
        end
      end
      MC_DONE: state_d = MC_IDLE;
      default: state_d = MC_IDLE;
    endcase

    if (flush_i && state_q != MC_IDLE) begin
      state_d   = MC_IDLE;
      clr_tag_d = 1'b0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= MC_IDLE;
      cnt_q         <= '0;
      rsp_pending_q <= 1'b0;
      clr_tag_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rsp_pending_q <= rsp_pending_d;
      clr_tag_q     <= clr_tag_d;
      err_q         <= err_d;
    end
  end

  assign busy_o       = (state_q != MC_IDLE);
  assign sbnd_stage_o = (state_q == MC_SBND2);
  assign done_o       = ((state_q == MC_DONE) || (state_q == MC_SBND2)) && !flush_i;
  assign clr_tag_o    = clr_tag_q;
  assign err_o        = err_q;

`ifndef SYNTHESIS
  a_start_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    start_i |-> $onehot0({op_sbnd_i, op_clc_i}));
  a_no_start_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    start_i |-> !busy_o);
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    (trvk_req_o && !trvk_gnt_i) |=> trvk_req_o);
`endif

endmodule

// File: tb/tb_cheri_mc_seq.sv
// Bench for cheri_mc_seq: CLC vector table with a done-scoreboard, plus
// hand-written sequences for bounds, timeout, late response, flush and reset.
module tb_cheri_mc_seq;

  localparam int unsigned TO = 16;

  logic clk_i = 1'b0;
  logic rst_i, start_i, op_sbnd_i, op_clc_i, flush_i;
  logic lsu_resp_valid_i, lsu_resp_err_i, lsu_tag_i;
  logic trvk_gnt_i, trvk_rsp_valid_i, trvk_rsp_revoked_i;
  logic trvk_req_o, busy_o, done_o, sbnd_stage_o, clr_tag_o, err_o;
  logic trvk_req_0, busy_0, done_0, sbnd_stage_0, clr_tag_0, err_0;

  always #5 clk_i = ~clk_i;

  cheri_mc_seq #(.CheriSBND2(1'b1), .TrvkTimeout(TO)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_sbnd_i(op_sbnd_i),
    .op_clc_i(op_clc_i), .flush_i(flush_i), .lsu_resp_valid_i(lsu_resp_valid_i),
    .lsu_resp_err_i(lsu_resp_err_i), .lsu_tag_i(lsu_tag_i), .trvk_req_o(trvk_req_o),
    .trvk_gnt_i(trvk_gnt_i), .trvk_rsp_valid_i(trvk_rsp_valid_i),
    .trvk_rsp_revoked_i(trvk_rsp_revoked_i), .busy_o(busy_o), .done_o(done_o),
    .sbnd_stage_o(sbnd_stage_o), .clr_tag_o(clr_tag_o), .err_o(err_o));

  cheri_mc_seq #(.CheriSBND2(1'b0), .TrvkTimeout(TO)) u_dut_nosbnd (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_sbnd_i(op_sbnd_i),
    .op_clc_i(op_clc_i), .flush_i(flush_i), .lsu_resp_valid_i(lsu_resp_valid_i),
    .lsu_resp_err_i(lsu_resp_err_i), .lsu_tag_i(lsu_tag_i), .trvk_req_o(trvk_req_0),
    .trvk_gnt_i(trvk_gnt_i), .trvk_rsp_valid_i(trvk_rsp_valid_i),
    .trvk_rsp_revoked_i(trvk_rsp_revoked_i), .busy_o(busy_0), .done_o(done_0),
    .sbnd_stage_o(sbnd_stage_0), .clr_tag_o(clr_tag_0), .err_o(err_0));

  typedef struct {
    bit clr;
    bit err;
    bit stage;
  } exp_t;

  typedef struct {
    int lsu_dly;
    bit err;
    bit tag;
    int gnt_dly;
    int rsp_dly;   // -1: never answer, let the timeout fire
    bit revoked;
    bit exp_req;
    bit exp_clr;
    bit exp_err;
    int exp_lat;   // cycles from the first post-action sample to done_o
  } clc_vec_t;

  exp_t     sb_q[$];
  clc_vec_t vecs[5];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Caller must already be sitting at a negedge sample point.
  task automatic wait_done(input int exp_wait, input string name);
    int n = 0;
    while (done_o !== 1'b1 && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    chk(name, n, exp_wait);
  endtask

  // Scoreboard: every done_o pulse must match the oldest pending expectation.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0 && done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("done_clr_tag", clr_tag_o, e.clr);
        chk("done_err", err_o, e.err);
        chk("done_sbnd_stage", sbnd_stage_o, e.stage);
      end
    end
  end

  task automatic run_clc(input clc_vec_t v, input int idx);
    sb_q.push_back('{clr: v.exp_clr, err: v.exp_err, stage: 1'b0});
    start_i = 1; op_clc_i = 1;
    step();
    start_i = 0; op_clc_i = 0;
    repeat (v.lsu_dly) step();
    lsu_resp_valid_i = 1; lsu_resp_err_i = v.err; lsu_tag_i = v.tag;
    step();
    lsu_resp_valid_i = 0; lsu_resp_err_i = 0; lsu_tag_i = 0;
    if (v.exp_req) begin
      for (int i = 0; i < v.gnt_dly; i++) begin
        @(negedge clk_i);
        chk($sformatf("v%0d_req_held", idx), trvk_req_o, 1);
        step();
      end
      trvk_gnt_i = 1;
      @(negedge clk_i);
      chk($sformatf("v%0d_req", idx), trvk_req_o, 1);
      step();
      trvk_gnt_i = 0;
      if (v.rsp_dly >= 0) begin
        repeat (v.rsp_dly) step();
        trvk_rsp_valid_i = 1; trvk_rsp_revoked_i = v.revoked;
        step();
        trvk_rsp_valid_i = 0; trvk_rsp_revoked_i = 0;
      end
      @(negedge clk_i);
    end else begin
      @(negedge clk_i);
      chk($sformatf("v%0d_no_req", idx), trvk_req_o, 0);
    end
    wait_done(v.exp_lat, $sformatf("v%0d_latency", idx));
    step();
    @(negedge clk_i);
    chk($sformatf("v%0d_idle_after", idx), {busy_o, clr_tag_o, err_o}, 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                lsu err tag gnt rsp rev req clr err lat
    vecs[0] = '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0};   // tag=0: no lookup
    vecs[1] = '{1, 0, 1, 2, 3, 1, 1, 1, 0, 0};   // revoked after delayed grant
    vecs[2] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0};   // lookup says not revoked
    vecs[3] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 0};   // LSU error
    vecs[4] = '{0, 0, 1, 1, -1, 0, 1, 1, 0, TO}; // no answer: timeout

    rst_i = 1; start_i = 0; op_sbnd_i = 0; op_clc_i = 0; flush_i = 0;
    lsu_resp_valid_i = 0; lsu_resp_err_i = 0; lsu_tag_i = 0;
    trvk_gnt_i = 0; trvk_rsp_valid_i = 0; trvk_rsp_revoked_i = 0;
    step(); step();
    @(negedge clk_i);
    chk("reset_outputs", {trvk_req_o, busy_o, done_o, sbnd_stage_o, clr_tag_o, err_o}, 0);
    rst_i = 0;
    step();

    // Two-cycle bounds op, and the same op on an instance without the sequence.
    sb_q.push_back('{clr: 1'b0, err: 1'b0, stage: 1'b1});
    start_i = 1; op_sbnd_i = 1;
    @(negedge clk_i);
    chk("sbnd_t0_done", done_o, 0);
    step();
    start_i = 0; op_sbnd_i = 0;
    @(negedge clk_i);
    chk("sbnd_t1_stage_done", {sbnd_stage_o, done_o, busy_o}, 3'b111);
    chk("nosbnd_t1_busy", {busy_0, done_0, sbnd_stage_0}, 0);
    step();
    @(negedge clk_i);
    chk("sbnd_t2_idle", {busy_o, sbnd_stage_o, done_o}, 0);
    step();

    for (int i = 0; i < 5; i++) run_clc(vecs[i], i);

    // The timed-out lookup is still outstanding: next request must wait for it.
    sb_q.push_back('{clr: 1'b0, err: 1'b0, stage: 1'b0});
    start_i = 1; op_clc_i = 1;
    step();
    start_i = 0; op_clc_i = 0;
    lsu_resp_valid_i = 1; lsu_tag_i = 1;
    step();
    lsu_resp_valid_i = 0; lsu_tag_i = 0;
    trvk_gnt_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("late_req_blocked", trvk_req_o, 0);
      step();
    end
    trvk_gnt_i = 0; trvk_rsp_valid_i = 1; trvk_rsp_revoked_i = 1;
    @(negedge clk_i);
    chk("late_absorb_cycle", {trvk_req_o, busy_o, done_o}, 3'b010);
    step();
    trvk_rsp_valid_i = 0; trvk_rsp_revoked_i = 0;
    @(negedge clk_i);
    chk("late_req_released", trvk_req_o, 1);
    trvk_gnt_i = 1;
    step();
    trvk_gnt_i = 0;
    trvk_rsp_valid_i = 1;
    step();
    trvk_rsp_valid_i = 0;
    @(negedge clk_i);
    wait_done(0, "late_latency");
    step();

    // Flush during the lookup wait; the orphaned response must be discarded.
    start_i = 1; op_clc_i = 1;
    step();
    start_i = 0; op_clc_i = 0;
    lsu_resp_valid_i = 1; lsu_tag_i = 1;
    step();
    lsu_resp_valid_i = 0; lsu_tag_i = 0;
    trvk_gnt_i = 1;
    step();
    trvk_gnt_i = 0;
    step();
    flush_i = 1;
    @(negedge clk_i);
    chk("flush_cycle", {busy_o, done_o}, 2'b10);
    step();
    flush_i = 0;
    @(negedge clk_i);
    chk("flush_idle", {busy_o, done_o, clr_tag_o}, 0);
    step(); step();
    trvk_rsp_valid_i = 1; trvk_rsp_revoked_i = 1;
    step();
    trvk_rsp_valid_i = 0; trvk_rsp_revoked_i = 0;
    @(negedge clk_i);
    chk("flush_rsp_discarded", {busy_o, done_o, clr_tag_o}, 0);
    step();
    run_clc(vecs[2], 5);

    // Start coinciding with flush is dropped.
    start_i = 1; op_clc_i = 1; flush_i = 1;
    step();
    start_i = 0; op_clc_i = 0; flush_i = 0;
    @(negedge clk_i);
    chk("start_with_flush", busy_o, 0);
    step();

    // Reset while waiting on the LSU.
    start_i = 1; op_clc_i = 1;
    step();
    start_i = 0; op_clc_i = 0;
    @(negedge clk_i);
    chk("rst_pre_busy", busy_o, 1);
    rst_i = 1;
    step();
    rst_i = 0;
    @(negedge clk_i);
    chk("rst_mid_outputs", {trvk_req_o, busy_o, done_o, sbnd_stage_o, clr_tag_o, err_o}, 0);
    step(); step();

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
